alu_decoder: RTL and testbench
==============================

# alu_decoder

Registered decode stage that turns a 32-bit RV32I instruction word into the 4-bit `i_ALUControl` code, operand-select and illegal flags consumed by the ALU. It sits between instruction fetch and the execute stage. It uses valid/ready handshakes on both sides, so fetch and execute can stall independently.

## Interface
- No parameters; widths are fixed (instruction 32, ALU control 4).
- `i_clk`  input  1  rising-edge clock.
- `i_reset`  input  1  synchronous reset, active-high.
- `i_valid`  input  1  upstream instruction valid.
- `i_instr`  input  32  instruction word.
- `o_ready`  output  1  decoder can accept `i_instr` this cycle.
- `o_valid`  output  1  decoded result valid.
- `i_ready`  input  1  downstream (execute) accepts result.
- `o_ALUControl`  output  4  ALU operation code.
- `o_alusrc`  output  1  1 = second ALU operand is immediate, 0 = register.
- `o_illegal`  output  1  instruction has no ALU mapping.
- `o_instr`  output  32  instruction word, passed through alongside its decode.

## Operation
- Decode uses opcode `[6:0]`, funct3 `[14:12]` and funct7 bit `[30]`.
- R-type (0110011), `o_alusrc`=0, funct3 → code:
  - 000 → 0010 (ADD) if bit30=0, 0110 (SUB) if bit30=1.
  - 001 → 1000 (SLL).
  - 100 → 0011 (XOR).
  - 101 → 1001 (SRL) if bit30=0, 1010 (SRA) if bit30=1.
  - 110 → 0001 (OR).
  - 111 → 0000 (AND).
- I-ALU (0010011), `o_alusrc`=1: same mapping as R-type, except funct3 000 is always 0010 (no SUBI); bit30 selects SRLI/SRAI only.
- Load (0000011) and store (0100011): 0010, `o_alusrc`=1.
- Branch (1100011): funct3 000/001/100/101 → 0110, `o_alusrc`=0; funct3 010/011/110/111 are illegal.
- Illegal cases: funct3 010/011 (SLT/SLTU) in R or I, any unlisted opcode, illegal branch funct3.
  - Output: `o_illegal`=1, `o_ALUControl`=0000, `o_alusrc`=0.
  - The entry is still passed downstream as a normal beat; it is not dropped.
- Handshake: input transfer when `i_valid & o_ready`; output transfer when `o_valid & i_ready`.
- Entries leave in acceptance order; no reordering, duplication or loss.

## Timing
- Reset values: `o_valid`=0, `o_ALUControl`=0000, `o_alusrc`=0, `o_illegal`=0, `o_instr`=0, `o_ready`=1. Reset flushes all buffered entries.
- Latency: an instruction accepted at edge N is presented with `o_valid`=1 after edge N (cycle N+1).
- While `o_valid & !i_ready`, all outputs hold stable.
- Simultaneous accept and drain in the same cycle with one entry held: the old entry leaves, the new entry takes its place, `o_valid` stays 1 and occupancy is unchanged.
- Reset asserted mid-stream wins over any handshake that cycle. The next cycle shows reset values, and nothing accepted before reset appears afterwards.
- `i_instr` is sampled only on accept; its value is don't-care when `i_valid`=0.

## Configuration
- Macro: `ALU_DECODER_SKID_EN`.
- Defined: two-entry skid buffer (output register plus skid register).
  - `o_ready` is driven directly from a flop: 1 when the skid register is empty.
  - Full throughput under backpressure; a third beat is refused until a drain occurs.
- Undefined: single output register.
  - `o_ready = !o_valid | i_ready` (combinational path from `i_ready`).
  - Same decode and latency; at most one entry held.

## Test plan
- R-type ADD/SUB: `0x002081B3`, then `0x402081B3`, `i_ready`=1 → `o_ALUControl` 0010 then 0110, `o_alusrc`=0, one cycle after each accept.
- SRAI: `0x4030D193` → `o_ALUControl`=1010, `o_alusrc`=1, `o_illegal`=0.
- Illegal: `0x0020A1B3` (SLT) and `0x0000007F` → `o_illegal`=1, `o_ALUControl`=0000, `o_valid`=1; both are delivered in order.
- Backpressure with skid: `i_ready`=0, offer ADD, SUB, XOR back-to-back.
  - ADD and SUB are accepted; `o_ready` is 0 in the cycle XOR is offered.
  - Raise `i_ready` → ADD, SUB, XOR emerge in order, with no duplicate.
  - Without the macro: only ADD is held until the drain.
- Streaming: `i_valid`=`i_ready`=1 for 8 cycles → 8 results on consecutive cycles, `o_ready` never drops.
- Reset mid-stream: assert `i_reset` while 2 entries are held → next cycle `o_valid`=0, `o_ready`=1, outputs at reset values; neither entry is ever presented.

Source files
------------

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - registered RV32I ALU-control decode stage with valid/ready handshakes
// Define ALU_DECODER_SKID_EN for a two-entry skid buffer with a flopped o_ready.
module alu_decoder (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic [31:0] i_instr,
  output logic        o_ready,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [3:0]  o_ALUControl,
  output logic        o_alusrc,
  output logic        o_illegal,
  output logic [31:0] o_instr
);

  typedef struct packed {
    logic [3:0]  alu;
    logic        alusrc;
    logic        illegal;
    logic [31:0] instr;
  } entry_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  entry_t     dec;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       bit30;

  assign opcode = i_instr[6:0];
  assign funct3 = i_instr[14:12];
  assign bit30  = i_instr[30];

  always_comb begin
    dec         = '0;
    dec.instr   = i_instr;
    case (opcode)
      OP_R, OP_I: begin
        dec.alusrc = (opcode == OP_I);
        case (funct3)
          3'b000:  dec.alu = (opcode == OP_R && bit30) ? 4'b0110 : 4'b0010;
          3'b001:  dec.alu = 4'b1000;
          3'b100:  dec.alu = 4'b0011;
          3'b101:  dec.alu = bit30 ? 4'b1010 : 4'b1001;
          3'b110:  dec.alu = 4'b0001;
          3'b111:  dec.alu = 4'b0000;
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_LOAD, OP_STORE: begin
        dec.alu    = 4'b0010;
        dec.alusrc = 1'b1;
      end
      OP_BRANCH: begin
        if (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b100 || funct3 == 3'b101)
          dec.alu = 4'b0110;
        else
          dec.illegal = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    // Illegal entries still travel downstream, but with a neutral ALU setup.
    if (dec.illegal) begin
      dec.alu    = 4'b0000;
      dec.alusrc = 1'b0;
    end
  end

  entry_t out_q;
  logic   out_valid;

  assign o_valid      = out_valid;
  assign o_ALUControl = out_q.alu;
  assign o_alusrc     = out_q.alusrc;
  assign o_illegal    = out_q.illegal;
  assign o_instr      = out_q.instr;

`ifdef ALU_DECODER_SKID_EN
  entry_t skid_q;
  logic   skid_valid;
  logic   ready_q;
  logic   accept;
  logic   drain;

  assign o_ready = ready_q;
  assign accept  = i_valid & ready_q;
  assign drain   = out_valid & i_ready;

  // ready_q always mirrors an empty skid register, so o_ready has no path from i_ready.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      out_q      <= '0;
      out_valid  <= 1'b0;
      skid_q     <= '0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
    end else if (skid_valid) begin
      if (drain) begin
        out_q      <= skid_q;
        skid_valid <= 1'b0;
        ready_q    <= 1'b1;
      end
    end else if (!out_valid || drain) begin
      out_valid <= accept;
      if (accept)
        out_q <= dec;
    end else if (accept) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
      ready_q    <= 1'b0;
    end
  end
`else
  assign o_ready = !out_valid | i_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      out_q     <= '0;
      out_valid <= 1'b0;
    end else if (o_ready) begin
      out_valid <= i_valid;
      if (i_valid)
        out_q <= dec;
    end
  end
`endif

endmodule

// File: tb/tb_alu_decoder.sv
// tb/tb_alu_decoder.sv - self-checking bench for alu_decoder: queue model plus directed vectors
// Build with or without ALU_DECODER_SKID_EN; expectations follow the selected configuration.
module tb_alu_decoder;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic [31:0] i_instr;
  logic        o_ready;
  logic        o_valid;
  logic        i_ready;
  logic [3:0]  o_ALUControl;
  logic        o_alusrc;
  logic        o_illegal;
  logic [31:0] o_instr;

  alu_decoder dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_valid      (i_valid),
    .i_instr      (i_instr),
    .o_ready      (o_ready),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_ALUControl (o_ALUControl),
    .o_alusrc     (o_alusrc),
    .o_illegal    (o_illegal),
    .o_instr      (o_instr)
  );

  always #5 i_clk = ~i_clk;

  localparam logic [31:0] ADD  = 32'h002081B3;
  localparam logic [31:0] SUB  = 32'h402081B3;
  localparam logic [31:0] XOR  = 32'h0020C1B3;
  localparam logic [31:0] SLT  = 32'h0020A1B3;
  localparam logic [31:0] BAD  = 32'h0000007F;
  localparam logic [31:0] SRAI = 32'h4030D193;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  alu;
    logic        src;
    logic        ill;
    logic [31:0] instr;
  } exp_t;

  exp_t        q[$];
  logic [31:0] delivered[$];
  logic [31:0] seq[$];
  logic [31:0] rdy_pat;
  logic        ready_log[32];
  logic        valid_log[32];
  logic        src_log[32];
  logic        ill_log[32];
  logic [3:0]  alu_log[32];
  logic [31:0] instr_log[32];

  function automatic exp_t model(input logic [31:0] w);
    logic [3:0] base[8];
    exp_t e;
    int   f3;
    base  = '{4'h2, 4'h8, 4'h0, 4'h0, 4'h3, 4'h9, 4'h1, 4'h0};
    f3    = int'(w[14:12]);
    e.instr = w;
    e.alu = 4'h0;
    e.src = 1'b0;
    e.ill = 1'b0;
    if (w[6:0] == 7'h33 || w[6:0] == 7'h13) begin
      if (f3 == 2 || f3 == 3) e.ill = 1'b1;
      else begin
        e.alu = base[f3];
        if (w[30] && f3 == 5) e.alu = 4'hA;
        if (w[30] && f3 == 0 && w[6:0] == 7'h33) e.alu = 4'h6;
        e.src = (w[6:0] == 7'h13);
      end
    end else if (w[6:0] == 7'h03 || w[6:0] == 7'h23) begin
      e.alu = 4'h2;
      e.src = 1'b1;
    end else if (w[6:0] == 7'h63) begin
      if (f3 == 0 || f3 == 1 || f3 == 4 || f3 == 5) e.alu = 4'h6;
      else e.ill = 1'b1;
    end else e.ill = 1'b1;
    return e;
  endfunction

  function automatic bit ready_f(input int n, input logic rdy);
`ifdef ALU_DECODER_SKID_EN
    return n < 2;
`else
    return n == 0 || rdy == 1'b1;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Occupancy model: a FIFO of expected entries bounded by the configured capacity.
  always @(posedge i_clk) begin
    if (i_reset) q.delete();
    else if (i_valid && ready_f(q.size(), i_ready)) begin
      if (q.size() > 0 && i_ready) void'(q.pop_front());
      q.push_back(model(i_instr));
    end else if (q.size() > 0 && i_ready) void'(q.pop_front());
  end

  always @(negedge i_clk) begin
    check("mon_valid", 64'(o_valid), 64'(q.size() > 0));
    check("mon_ready", 64'(o_ready), 64'(ready_f(q.size(), i_ready)));
    if (q.size() > 0) begin
      check("mon_alu",   64'(o_ALUControl), 64'(q[0].alu));
      check("mon_src",   64'(o_alusrc),     64'(q[0].src));
      check("mon_ill",   64'(o_illegal),    64'(q[0].ill));
      check("mon_instr", 64'(o_instr),      64'(q[0].instr));
    end
    if (!i_reset && o_valid && i_ready) delivered.push_back(o_instr);
  end

  task automatic run_seq(input int ncyc);
    int idx;
    bit acc;
    idx = 0;
    for (int c = 0; c < ncyc; c++) begin
      i_ready = rdy_pat[c];
      i_valid = (idx < seq.size());
      i_instr = i_valid ? seq[idx] : 32'hDEADBEEF;
      @(negedge i_clk);
      ready_log[c] = o_ready;
      valid_log[c] = o_valid;
      alu_log[c]   = o_ALUControl;
      src_log[c]   = o_alusrc;
      ill_log[c]   = o_illegal;
      instr_log[c] = o_instr;
      acc = i_valid && o_ready;
      @(posedge i_clk);
      #1;
      if (acc) idx++;
    end
    i_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, 64'(o_valid), 64'd0);
    check({tag, "_ready"}, 64'(o_ready), 64'd1);
    check({tag, "_alu"},   64'(o_ALUControl), 64'd0);
    check({tag, "_src"},   64'(o_alusrc), 64'd0);
    check({tag, "_ill"},   64'(o_illegal), 64'd0);
    check({tag, "_instr"}, 64'(o_instr), 64'd0);
  endtask

  initial begin
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_instr = '0;
    repeat (2) @(posedge i_clk);
    #1;
    check_reset_values("reset");
    i_reset = 1'b0;

    seq = '{ADD, SUB};
    rdy_pat = '1;
    run_seq(3);
    check("addsub_valid", 64'(valid_log[1]), 64'd1);
    check("add_alu", 64'(alu_log[1]), 64'h2);
    check("add_src", 64'(src_log[1]), 64'd0);
    check("sub_alu", 64'(alu_log[2]), 64'h6);
    check("sub_src", 64'(src_log[2]), 64'd0);

    seq = '{SRAI};
    run_seq(2);
    check("srai_alu", 64'(alu_log[1]), 64'hA);
    check("srai_src", 64'(src_log[1]), 64'd1);
    check("srai_ill", 64'(ill_log[1]), 64'd0);

    seq = '{SLT, BAD};
    delivered.delete();
    run_seq(3);
    check("slt_ill",   64'(ill_log[1]), 64'd1);
    check("slt_alu",   64'(alu_log[1]), 64'h0);
    check("slt_valid", 64'(valid_log[1]), 64'd1);
    check("bad_ill",   64'(ill_log[2]), 64'd1);
    check("bad_alu",   64'(alu_log[2]), 64'h0);
    check("ill_order_n", 64'(delivered.size()), 64'd2);
    if (delivered.size() == 2) begin
      check("ill_order_0", 64'(delivered[0]), 64'(SLT));
      check("ill_order_1", 64'(delivered[1]), 64'(BAD));
    end

    seq = '{ADD, SUB, XOR};
    rdy_pat = 32'hFFFF_FFF0;
    delivered.delete();
    run_seq(9);
`ifdef ALU_DECODER_SKID_EN
    check("bp_ready_sub", 64'(ready_log[1]), 64'd1);
    check("bp_ready_xor", 64'(ready_log[2]), 64'd0);
`else
    check("bp_ready_sub", 64'(ready_log[1]), 64'd0);
`endif
    check("bp_hold_instr", 64'(instr_log[3]), 64'(ADD));
    check("bp_n", 64'(delivered.size()), 64'd3);
    if (delivered.size() == 3) begin
      check("bp_order_0", 64'(delivered[0]), 64'(ADD));
      check("bp_order_1", 64'(delivered[1]), 64'(SUB));
      check("bp_order_2", 64'(delivered[2]), 64'(XOR));
    end

    seq = '{ADD, 32'h0000A083, 32'h0020A023, 32'h00208063,
            32'h0020A063, 32'h0FF0F093, SUB, 32'h00209033};
    rdy_pat = '1;
    delivered.delete();
    run_seq(10);
    for (int c = 0; c < 8; c++) check("stream_ready", 64'(ready_log[c]), 64'd1);
    for (int c = 1; c <= 8; c++) check("stream_valid", 64'(valid_log[c]), 64'd1);
    check("stream_n", 64'(delivered.size()), 64'd8);

    seq = '{ADD, SUB};
    rdy_pat = '0;
    delivered.delete();
    run_seq(3);
    i_reset = 1'b1;
    i_valid = 1'b1;
    i_instr = XOR;
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    i_valid = 1'b0;
    check_reset_values("midrst");
    repeat (4) @(posedge i_clk);
    #1;
    check("midrst_none", 64'(delivered.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
